lb_master: RTL and testbench
============================

Name: lb_master

Overview:
- Local-bus initiator that drives the lb_wr/lb_rd/lb_addr/lb_wr_d interface consumed by the SUMP2 core wrapper and collects lb_rd_d/lb_rd_rdy.
- Accepts one command at a time (single write or N-word read burst) over a valid/ready handshake and returns one response beat per bus access.
- Sits between a host link bridge (UART/USB) and the local-bus responders.
- Burst reads with zero stride drain the SUMP2 data port (addr 0x4) without host round-trips.

Parameters:
- ADDR_INC, 0, byte stride added to lb_addr after each read beat. 0 gives a fixed address; 4 gives incrementing dwords.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for lb_rd_rdy. Used only with LB_MASTER_TIMEOUT_EN.

Ports:
- clk_lb  in  1  local-bus clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  32  start address
- cmd_wdata  in  32  write data
- cmd_len  in  8  read beats minus 1 (0 gives 1 beat, 255 gives 256); ignored for writes
- rsp_valid  out  1  response beat present
- rsp_ready  in  1  response consumed
- rsp_data  out  32  read data; 0 for write acks
- rsp_last  out  1  final beat of the command
- rsp_err  out  1  beat terminated by timeout
- lb_wr  out  1  one-cycle write strobe
- lb_rd  out  1  one-cycle read strobe
- lb_addr  out  32  bus address
- lb_wr_d  out  32  bus write data
- lb_rd_d  in  32  read data from responder
- lb_rd_rdy  in  1  read data valid

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset mid-burst abandons the burst with no response.
- States: IDLE, WR, RD_ISSUE, RD_WAIT, RSP.
- IDLE
  - cmd_ready = 1 only in IDLE.
  - On handshake, latch addr, wdata, len and wr into internal registers.
  - Go to WR if wr = 1, otherwise RD_ISSUE.
- WR
  - lb_wr = 1 for exactly one cycle, with lb_addr and lb_wr_d valid in the same cycle.
  - Next state RSP with rsp_data = 0, rsp_last = 1, rsp_err = 0.
- RD_ISSUE
  - lb_rd = 1 for exactly one cycle, with lb_addr valid. Next state RD_WAIT.
- RD_WAIT
  - Hold until lb_rd_rdy = 1, then capture lb_rd_d into rsp_data.
  - rsp_last = 1 when the remaining-beat counter is 0. Next state RSP.
- RSP
  - rsp_valid = 1; rsp_data, rsp_last and rsp_err are held stable until rsp_ready.
  - On rsp_ready with last = 1: go to IDLE.
  - On rsp_ready with last = 0: lb_addr += ADDR_INC (32-bit modulo wrap), counter -= 1, go to RD_ISSUE.
- Bus outputs: lb_addr and lb_wr_d stay stable between strobes. lb_wr and lb_rd are never asserted together.
- Latency (accept cycle = T):
  - Write: lb_wr at T+1, rsp_valid at T+2.
  - Read: lb_rd at T+1; lb_rd_rdy at cycle R gives rsp_valid at R+1.
  - A lb_rd_rdy arriving in the same cycle as lb_rd is legal and is captured.
  - Each further read beat takes at least 3 cycles after rsp_ready.
- lb_rd_rdy outside RD_WAIT (stray or late) is ignored.
- rsp_ready held high: the burst streams with no stall beyond the latencies above.
- Address wrap from 0xFFFFFFFC with ADDR_INC = 4 goes to 0x00000000 with no error.

Optional Feature:
- Macro LB_MASTER_TIMEOUT_EN.
- With the macro:
  - An 8..16-bit counter clears on entry to RD_WAIT.
  - If TIMEOUT_CYCLES elapse without lb_rd_rdy, go to RSP with rsp_data = 0xDEADBEEF, rsp_err = 1, rsp_last = 1. The rest of the burst is abandoned.
- Without the macro: no counter exists, rsp_err is tied to 0, and RD_WAIT waits indefinitely.

Decomposition:
- Package lb_master_pkg holds:
  - the state enum (IDLE/WR/RD_ISSUE/RD_WAIT/RSP);
  - the LB_TIMEOUT_DATA constant 32'hDEADBEEF;
  - the SUMP2 address constants LB_SUMP2_CTRL = 0x0 and LB_SUMP2_DATA = 0x4.
- No sub-module: the state machine, beat counter and timeout counter are small enough to stay inline.

Test Plan:
- Write cmd addr 0x0, wdata 0x00000012 → one-cycle lb_wr at T+1 with lb_addr 0x0, lb_wr_d 0x12; rsp_valid at T+2 with data 0, last 1.
- Read addr 0x4, len 0, responder rdy 3 cycles after lb_rd with data 0xA5A50001 → single rsp with data 0xA5A50001, last 1; exactly one lb_rd pulse.
- Read len 3, ADDR_INC 0, rsp_ready held 1 → 4 lb_rd pulses all at 0x4, 4 responses with last only on beat 4, data in order.
- Read len 2, ADDR_INC 4, start 0xFFFFFFFC, rsp_ready deasserted for 5 cycles on beat 1 → addresses FFFFFFFC, 0, 4; beat 1 rsp fields held stable and no new lb_rd during the stall.
- Stray lb_rd_rdy in IDLE and RSP, plus reset asserted in RD_WAIT → no response; all outputs 0 immediately; next command runs normally.
- With LB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES 16, read len 5 with no rdy → rsp data 0xDEADBEEF, err 1, last 1; no further lb_rd; back to IDLE.

Source files
------------

// File: rtl/lb_master_pkg.sv
// Shared state encoding and constants for the lb_master local-bus initiator.
package lb_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RSP
  } lb_state_e;

  localparam logic [31:0] LB_TIMEOUT_DATA = 32'hDEADBEEF;

  // SUMP2 core wrapper register map.
  localparam logic [31:0] LB_SUMP2_CTRL = 32'h0000_0000;
  localparam logic [31:0] LB_SUMP2_DATA = 32'h0000_0004;

  localparam int LB_TO_CNT_W = 16;

endpackage

// File: rtl/lb_master.sv
// lb_master: one-command-at-a-time local-bus initiator (single writes, N-beat read bursts).
// Define LB_MASTER_TIMEOUT_EN to bound the wait for lb_rd_rdy by TIMEOUT_CYCLES.
module lb_master
  import lb_master_pkg::*;
#(
  parameter int unsigned ADDR_INC       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_lb,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [7:0]  cmd_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic        lb_wr,
  output logic        lb_rd,
  output logic [31:0] lb_addr,
  output logic [31:0] lb_wr_d,
  input  logic [31:0] lb_rd_d,
  input  logic        lb_rd_rdy
);

  localparam logic [31:0] ADDR_STEP = 32'(ADDR_INC);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("lb_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  lb_state_e   state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        wr_stb_q, wr_stb_d;
  logic        rd_stb_q, rd_stb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  beats_q, beats_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_last_q, rsp_last_d;
  logic        cmd_fire;

  assign cmd_fire = cmd_valid && cmd_ready_q;

`ifdef LB_MASTER_TIMEOUT_EN
  localparam logic [LB_TO_CNT_W-1:0] TO_LAST = LB_TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [LB_TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   timed_out;

  assign timed_out = (to_cnt_q == TO_LAST);
`endif

  // Every bus and response output is a flop, so each is computed one cycle
  // ahead as the value it must hold in the state being entered.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    wr_stb_d    = 1'b0;
    rd_stb_d    = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    beats_d     = beats_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
`ifdef LB_MASTER_TIMEOUT_EN
    to_cnt_d    = '0;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_fire) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          beats_d     = cmd_len;
          if (cmd_wr) begin
            wdata_d  = cmd_wdata;
            wr_stb_d = 1'b1;
            state_d  = ST_WR;
          end else begin
            rd_stb_d = 1'b1;
            state_d  = ST_RD_ISSUE;
          end
        end
      end
      ST_WR: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = '0;
        rsp_last_d  = 1'b1;
`ifdef LB_MASTER_TIMEOUT_EN
        rsp_err_d   = 1'b0;
`endif
        state_d     = ST_RSP;
      end
      // A responder may answer in the same cycle as the strobe, so both
      // issue and wait states accept lb_rd_rdy.
      ST_RD_ISSUE, ST_RD_WAIT: begin
        state_d = ST_RD_WAIT;
        if (lb_rd_rdy) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = lb_rd_d;
          rsp_last_d  = (beats_q == '0);
`ifdef LB_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = ST_RSP;
        end
`ifdef LB_MASTER_TIMEOUT_EN
        else if (state_q == ST_RD_WAIT) begin
          if (timed_out) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = LB_TIMEOUT_DATA;
            rsp_last_d  = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = ST_RSP;
          end else begin
            to_cnt_d = to_cnt_q + LB_TO_CNT_W'(1);
          end
        end
`endif
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            cmd_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            addr_d   = addr_q + ADDR_STEP;
            beats_d  = beats_q - 8'd1;
            rd_stb_d = 1'b1;
            state_d  = ST_RD_ISSUE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_lb or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      wr_stb_q    <= 1'b0;
      rd_stb_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      beats_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
`ifdef LB_MASTER_TIMEOUT_EN
      to_cnt_q    <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      wr_stb_q    <= wr_stb_d;
      rd_stb_q    <= rd_stb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      beats_q     <= beats_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
`ifdef LB_MASTER_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign lb_wr     = wr_stb_q;
  assign lb_rd     = rd_stb_q;
  assign lb_addr   = addr_q;
  assign lb_wr_d   = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
`ifdef LB_MASTER_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lb_master.sv
// Directed bench for lb_master: one DUT with a fixed read address, one incrementing by 4.
`timescale 1ns/1ps
module tb_lb_master;
  import lb_master_pkg::*;

  logic        clk_lb = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_wr, rsp_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [7:0]  cmd_len;
  logic [31:0] lb_rd_d;
  logic        lb_rd_rdy;

  logic        cmd_ready_0, rsp_valid_0, rsp_last_0, rsp_err_0, lb_wr_0, lb_rd_0;
  logic [31:0] rsp_data_0, lb_addr_0, lb_wr_d_0;
  logic        cmd_ready_4, rsp_valid_4, rsp_last_4, rsp_err_4, lb_wr_4, lb_rd_4;
  logic [31:0] rsp_data_4, lb_addr_4, lb_wr_d_4;

  // Responder controls written by the main sequence; resp_beat belongs to the responder.
  logic        stray_rdy, resp_mute;
  int          resp_delay;
  logic [31:0] resp_seed;
  int          resp_beat;

  int checks, errors;

  lb_master #(.ADDR_INC(0), .TIMEOUT_CYCLES(16)) u_dut0 (
    .clk_lb(clk_lb), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_0),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid_0), .rsp_ready(rsp_ready), .rsp_data(rsp_data_0),
    .rsp_last(rsp_last_0), .rsp_err(rsp_err_0), .lb_wr(lb_wr_0), .lb_rd(lb_rd_0),
    .lb_addr(lb_addr_0), .lb_wr_d(lb_wr_d_0), .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy)
  );

  lb_master #(.ADDR_INC(4), .TIMEOUT_CYCLES(16)) u_dut4 (
    .clk_lb(clk_lb), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_4),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready), .rsp_data(rsp_data_4),
    .rsp_last(rsp_last_4), .rsp_err(rsp_err_4), .lb_wr(lb_wr_4), .lb_rd(lb_rd_4),
    .lb_addr(lb_addr_4), .lb_wr_d(lb_wr_d_4), .lb_rd_d(lb_rd_d), .lb_rd_rdy(lb_rd_rdy)
  );

  always #5 clk_lb = ~clk_lb;

  // Responder: answers each lb_rd resp_delay cycles later with resp_seed + beat index.
  initial begin
    lb_rd_rdy = 1'b0;
    lb_rd_d   = '0;
    resp_beat = 0;
    forever begin
      @(posedge clk_lb); #2;
      lb_rd_rdy = stray_rdy;
      if (stray_rdy) lb_rd_d = 32'hBAD0_0BAD;
      if (cmd_ready_0) resp_beat = 0;
      if (lb_rd_0 && !resp_mute) begin
        repeat (resp_delay) begin
          @(posedge clk_lb); #2;
          lb_rd_rdy = 1'b0;
        end
        lb_rd_rdy = 1'b1;
        lb_rd_d   = resp_seed + 32'(resp_beat);
        resp_beat++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk_lb); #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [7:0] len);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_len = len;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++; if ({cmd_ready_0, rsp_valid_0, rsp_last_0, rsp_err_0, lb_wr_0, lb_rd_0} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_ctl0: got %b expected 000000", {cmd_ready_0, rsp_valid_0, rsp_last_0, rsp_err_0, lb_wr_0, lb_rd_0}); end
    checks++; if ({lb_addr_0, lb_wr_d_0, rsp_data_0} !== 96'b0) begin
      errors++; $display("[TB] FAIL reset_data0: got %h expected 0", {lb_addr_0, lb_wr_d_0, rsp_data_0}); end
    checks++; if ({cmd_ready_4, rsp_valid_4, lb_wr_4, lb_rd_4, lb_addr_4} !== 36'b0) begin
      errors++; $display("[TB] FAIL reset_dut4: got %h expected 0", {cmd_ready_4, rsp_valid_4, lb_wr_4, lb_rd_4, lb_addr_4}); end
    reset = 1'b0;
    step();
    checks++; if ({cmd_ready_0, cmd_ready_4} !== 2'b11) begin
      errors++; $display("[TB] FAIL reset_ready: got %b expected 11", {cmd_ready_0, cmd_ready_4}); end
  endtask

  task automatic test_write();
    issue(1'b1, LB_SUMP2_CTRL, 32'h0000_0012, 8'd0);
    checks++; if ({lb_wr_0, lb_rd_0, rsp_valid_0, cmd_ready_0} !== 4'b1000) begin
      errors++; $display("[TB] FAIL wr_strobe: got wr/rd/v/rdy=%b expected 1000", {lb_wr_0, lb_rd_0, rsp_valid_0, cmd_ready_0}); end
    checks++; if (lb_addr_0 !== 32'h0 || lb_wr_d_0 !== 32'h12) begin
      errors++; $display("[TB] FAIL wr_bus: got addr=%h data=%h expected 00000000 00000012", lb_addr_0, lb_wr_d_0); end
    step();
    checks++; if ({lb_wr_0, rsp_valid_0, rsp_last_0, rsp_err_0} !== 4'b0110) begin
      errors++; $display("[TB] FAIL wr_rsp: got wr/v/last/err=%b expected 0110", {lb_wr_0, rsp_valid_0, rsp_last_0, rsp_err_0}); end
    checks++; if (rsp_data_0 !== 32'h0 || lb_wr_d_0 !== 32'h12) begin
      errors++; $display("[TB] FAIL wr_rsp_data: got data=%h wr_d=%h expected 00000000 00000012", rsp_data_0, lb_wr_d_0); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    checks++; if ({rsp_valid_0, cmd_ready_0} !== 2'b01) begin
      errors++; $display("[TB] FAIL wr_done: got v/rdy=%b expected 01", {rsp_valid_0, cmd_ready_0}); end
  endtask

  task automatic test_single_read();
    int n, pulses;
    resp_seed = 32'hA5A5_0001; resp_delay = 3;
    issue(1'b0, LB_SUMP2_DATA, 32'h0, 8'd0);
    checks++; if (lb_rd_0 !== 1'b1 || lb_addr_0 !== 32'h4 || lb_wr_0 !== 1'b0) begin
      errors++; $display("[TB] FAIL rd1_strobe: got rd=%b wr=%b addr=%h expected 1 0 00000004", lb_rd_0, lb_wr_0, lb_addr_0); end
    n = 0; pulses = 0;
    while (!rsp_valid_0 && n < 50) begin
      if (lb_rd_0) pulses++;
      step(); n++;
    end
    checks++; if (n != 4) begin
      errors++; $display("[TB] FAIL rd1_latency: got %0d cycles expected 4", n); end
    checks++; if (pulses != 1) begin
      errors++; $display("[TB] FAIL rd1_pulses: got %0d expected 1", pulses); end
    checks++; if (rsp_data_0 !== 32'hA5A5_0001 || rsp_last_0 !== 1'b1 || rsp_err_0 !== 1'b0) begin
      errors++; $display("[TB] FAIL rd1_rsp: got data=%h last=%b err=%b expected a5a50001 1 0", rsp_data_0, rsp_last_0, rsp_err_0); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    checks++; if ({rsp_valid_0, cmd_ready_0} !== 2'b01) begin
      errors++; $display("[TB] FAIL rd1_done: got v/rdy=%b expected 01", {rsp_valid_0, cmd_ready_0}); end
  endtask

  task automatic test_burst_fixed();
    int cyc, beat, rd_n, last_rd;
    resp_seed = 32'h1111_0000; resp_delay = 1; rsp_ready = 1'b1;
    issue(1'b0, LB_SUMP2_DATA, 32'h0, 8'd3);
    cyc = 0; beat = 0; rd_n = 0; last_rd = 0;
    while (beat < 4 && cyc < 100) begin
      if (lb_rd_0) begin
        checks++; if (lb_addr_0 !== 32'h4) begin
          errors++; $display("[TB] FAIL burst_addr: got %h expected 00000004", lb_addr_0); end
        checks++; if (lb_addr_4 !== 32'h4 + 32'(4 * rd_n)) begin
          errors++; $display("[TB] FAIL burst_addr_inc: got %h expected %h", lb_addr_4, 32'h4 + 32'(4 * rd_n)); end
        if (rd_n > 0) begin
          checks++; if (cyc - last_rd != 3) begin
            errors++; $display("[TB] FAIL burst_spacing: got %0d cycles expected 3", cyc - last_rd); end
        end
        last_rd = cyc; rd_n++;
      end
      if (rsp_valid_0) begin
        checks++; if (rsp_data_0 !== resp_seed + 32'(beat) || rsp_last_0 !== (beat == 3)) begin
          errors++; $display("[TB] FAIL burst_beat%0d: got data=%h last=%b expected %h %b", beat, rsp_data_0, rsp_last_0, resp_seed + 32'(beat), beat == 3); end
        beat++;
      end
      step(); cyc++;
    end
    rsp_ready = 1'b0;
    checks++; if (beat != 4 || rd_n != 4) begin
      errors++; $display("[TB] FAIL burst_count: got beats=%0d strobes=%0d expected 4 4", beat, rd_n); end
    checks++; if (cmd_ready_0 !== 1'b1) begin
      errors++; $display("[TB] FAIL burst_done: got rdy=%b expected 1", cmd_ready_0); end
  endtask

  task automatic test_wrap_stall();
    int cyc, beat, rd_n;
    logic stalled;
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFFC; exp_a[1] = 32'h0000_0000; exp_a[2] = 32'h0000_0004;
    resp_seed = 32'h2222_0000; resp_delay = 2; rsp_ready = 1'b0;
    issue(1'b0, 32'hFFFF_FFFC, 32'h0, 8'd2);
    cyc = 0; beat = 0; rd_n = 0; stalled = 1'b0;
    while (beat < 3 && cyc < 200) begin
      if (lb_rd_0) begin
        if (rd_n < 3) begin
          checks++; if (lb_addr_4 !== exp_a[rd_n]) begin
            errors++; $display("[TB] FAIL wrap_addr%0d: got %h expected %h", rd_n, lb_addr_4, exp_a[rd_n]); end
        end
        checks++; if (lb_addr_0 !== 32'hFFFF_FFFC) begin
          errors++; $display("[TB] FAIL wrap_fixed_addr: got %h expected fffffffc", lb_addr_0); end
        rd_n++;
      end
      if (rsp_valid_0) begin
        if (!stalled) begin
          repeat (4) begin
            step(); cyc++;
            checks++; if ({rsp_valid_0, rsp_last_0, lb_rd_0} !== 3'b100 || rsp_data_0 !== 32'h2222_0000) begin
              errors++; $display("[TB] FAIL wrap_stall_hold: got v/last/rd=%b data=%h expected 100 22220000", {rsp_valid_0, rsp_last_0, lb_rd_0}, rsp_data_0); end
          end
          stalled = 1'b1; rsp_ready = 1'b1;
        end
        checks++; if (rsp_data_0 !== resp_seed + 32'(beat) || rsp_last_0 !== (beat == 2)) begin
          errors++; $display("[TB] FAIL wrap_beat%0d: got data=%h last=%b expected %h %b", beat, rsp_data_0, rsp_last_0, resp_seed + 32'(beat), beat == 2); end
        beat++;
      end
      step(); cyc++;
    end
    rsp_ready = 1'b0;
    checks++; if (beat != 3 || rd_n != 3 || cmd_ready_4 !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap_count: got beats=%0d strobes=%0d rdy=%b expected 3 3 1", beat, rd_n, cmd_ready_4); end
  endtask

  task automatic test_stray_and_reset();
    int n;
    stray_rdy = 1'b1;
    repeat (3) begin
      step();
      checks++; if ({cmd_ready_0, rsp_valid_0, lb_rd_0} !== 3'b100) begin
        errors++; $display("[TB] FAIL stray_idle: got rdy/v/rd=%b expected 100", {cmd_ready_0, rsp_valid_0, lb_rd_0}); end
    end
    stray_rdy = 1'b0;
    resp_seed = 32'h3333_0000; resp_delay = 1; rsp_ready = 1'b0;
    issue(1'b0, LB_SUMP2_DATA, 32'h0, 8'd1);
    n = 0;
    while (!rsp_valid_0 && n < 50) begin step(); n++; end
    checks++; if (rsp_valid_0 !== 1'b1) begin
      errors++; $display("[TB] FAIL stray_rsp_wait: got v=%b expected 1", rsp_valid_0); end
    stray_rdy = 1'b1;
    repeat (3) begin
      step();
      checks++; if ({rsp_valid_0, lb_rd_0} !== 2'b10 || rsp_data_0 !== 32'h3333_0000) begin
        errors++; $display("[TB] FAIL stray_rsp_hold: got v/rd=%b data=%h expected 10 33330000", {rsp_valid_0, lb_rd_0}, rsp_data_0); end
    end
    stray_rdy = 1'b0; resp_mute = 1'b1;
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    checks++; if (lb_rd_0 !== 1'b1) begin
      errors++; $display("[TB] FAIL stray_beat2_rd: got %b expected 1", lb_rd_0); end
    step(); step();
    #2 reset = 1'b1;
    #1;
    checks++; if ({cmd_ready_0, rsp_valid_0, rsp_last_0, lb_wr_0, lb_rd_0, lb_addr_0, lb_wr_d_0, rsp_data_0} !== 101'b0) begin
      errors++; $display("[TB] FAIL reset_mid_dut0: got addr=%h wr_d=%h v=%b expected 0", lb_addr_0, lb_wr_d_0, rsp_valid_0); end
    checks++; if ({cmd_ready_4, rsp_valid_4, lb_rd_4, lb_addr_4, lb_wr_d_4} !== 67'b0) begin
      errors++; $display("[TB] FAIL reset_mid_dut4: got addr=%h wr_d=%h expected 0", lb_addr_4, lb_wr_d_4); end
    step();
    reset = 1'b0; resp_mute = 1'b0;
    repeat (3) begin
      step();
      checks++; if ({cmd_ready_0, rsp_valid_0, lb_rd_0} !== 3'b100) begin
        errors++; $display("[TB] FAIL reset_quiet: got rdy/v/rd=%b expected 100", {cmd_ready_0, rsp_valid_0, lb_rd_0}); end
    end
    resp_seed = 32'h5A5A_0000; resp_delay = 0;
    issue(1'b0, LB_SUMP2_DATA, 32'h0, 8'd0);
    checks++; if (lb_rd_0 !== 1'b1) begin
      errors++; $display("[TB] FAIL resume_rd: got %b expected 1", lb_rd_0); end
    step();
    checks++; if ({rsp_valid_0, rsp_last_0} !== 2'b11 || rsp_data_0 !== 32'h5A5A_0000) begin
      errors++; $display("[TB] FAIL resume_same_cycle: got v/last=%b data=%h expected 11 5a5a0000", {rsp_valid_0, rsp_last_0}, rsp_data_0); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    checks++; if (cmd_ready_0 !== 1'b1) begin
      errors++; $display("[TB] FAIL resume_done: got rdy=%b expected 1", cmd_ready_0); end
  endtask

`ifdef LB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int n, pulses;
    resp_mute = 1'b1; rsp_ready = 1'b0;
    issue(1'b0, LB_SUMP2_DATA, 32'h0, 8'd5);
    n = 0; pulses = 0;
    while (!rsp_valid_0 && n < 100) begin
      if (lb_rd_0) pulses++;
      step(); n++;
    end
    checks++; if (n != 17 || pulses != 1) begin
      errors++; $display("[TB] FAIL to_latency: got cycles=%0d strobes=%0d expected 17 1", n, pulses); end
    checks++; if (rsp_data_0 !== LB_TIMEOUT_DATA || {rsp_err_0, rsp_last_0} !== 2'b11) begin
      errors++; $display("[TB] FAIL to_rsp: got data=%h err/last=%b expected deadbeef 11", rsp_data_0, {rsp_err_0, rsp_last_0}); end
    checks++; if (rsp_data_4 !== LB_TIMEOUT_DATA || rsp_err_4 !== 1'b1) begin
      errors++; $display("[TB] FAIL to_rsp4: got data=%h err=%b expected deadbeef 1", rsp_data_4, rsp_err_4); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    pulses = 0;
    repeat (10) begin
      if (lb_rd_0) pulses++;
      step();
    end
    checks++; if (pulses != 0 || cmd_ready_0 !== 1'b1 || rsp_valid_0 !== 1'b0) begin
      errors++; $display("[TB] FAIL to_abandon: got strobes=%0d rdy=%b v=%b expected 0 1 0", pulses, cmd_ready_0, rsp_valid_0); end
    resp_mute = 1'b0;
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_len = '0; rsp_ready = 1'b0;
    stray_rdy = 1'b0; resp_mute = 1'b0; resp_delay = 1; resp_seed = '0;
    test_reset();
    test_write();
    test_single_read();
    test_burst_fixed();
    test_wrap_stall();
    test_stray_and_reset();
`ifdef LB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
